// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// A grant lasts up to MAX_BURST words; ownership hands over with no idle cycle.

module fifo_write_arbiter_lane #(
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic              valid,
  input  logic              full,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic [DATA_W-1:0] data_out
);
  assign ready    = sel & valid & ~full;
  assign data_out = ready ? data : '0;
endmodule

module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_write_en,
  output logic [DATA_W-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [ID_W:0]    NREQ      = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                          state, state_n;
  logic [ID_W-1:0]                 grant_n, rr_ptr, rr_n;
  logic [CNT_W-1:0]                beat_cnt, beat_n;
  logic [NUM_REQ-1:0]              sel;
  logic [NUM_REQ-1:0][DATA_W-1:0]  lane_data;

  // Per-lane ready/data gating; only the owner's lane can pass anything.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign sel[i] = rst_n & (state == GRANT) & (grant_id == ID_W'(i));
    fifo_write_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
      .sel      (sel[i]),
      .valid    (req_valid[i]),
      .full     (fifo_full),
      .data     (req_data[i*DATA_W +: DATA_W]),
      .ready    (req_ready[i]),
      .data_out (lane_data[i])
    );
  end

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) fifo_data_in |= lane_data[i];
  end

  assign fifo_write_en = |req_ready;
  assign busy          = (state == GRANT);

  // Rotate requests so bit 0 is rr_ptr, pick the lowest set bit, rotate back.
  logic [2*NUM_REQ-1:0] dbl;
  logic                 arb_any;
  logic [ID_W-1:0]      arb_off, arb_idx, arb_nxt;
  logic [ID_W:0]        arb_sum;

  assign dbl = {req_valid, req_valid} >> rr_ptr;

  always_comb begin
    arb_any = 1'b0;
    arb_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        arb_any = 1'b1;
        arb_off = ID_W'(k);
      end
    end
    arb_sum = {1'b0, rr_ptr} + {1'b0, arb_off};
    arb_idx = (arb_sum >= NREQ) ? ID_W'(arb_sum - NREQ) : ID_W'(arb_sum);
    arb_nxt = (arb_idx == LAST_ID) ? '0 : arb_idx + 1'b1;
  end

  logic own_valid, burst_end;
  assign own_valid = |(req_valid & sel);
  assign burst_end = (fifo_write_en && beat_cnt == BEAT_LAST) || !own_valid;

  always_comb begin
    state_n = state;
    grant_n = grant_id;
    beat_n  = beat_cnt;
    rr_n    = rr_ptr;
    case (state)
      IDLE: begin
        if (arb_any) begin
          state_n = GRANT;
          grant_n = arb_idx;
          beat_n  = '0;
          rr_n    = arb_nxt;
        end
      end
      GRANT: begin
        if (fifo_write_en) beat_n = beat_cnt + 1'b1;
        if (burst_end) begin
          // Same-cycle re-arbitration keeps the port busy across handovers.
          if (arb_any) begin
            grant_n = arb_idx;
            beat_n  = '0;
            rr_n    = arb_nxt;
          end else begin
            state_n = IDLE;
            beat_n  = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_n;
      grant_id <= grant_n;
      beat_cnt <= beat_n;
      rr_ptr   <= rr_n;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: bursts, rotation, stalls, early drop, reset.

module tb_fifo_write_arbiter;
  logic        clk, rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_data;
  logic        fifo_full, fifo_write_en, busy;
  logic [7:0]  fifo_data_in;
  logic [1:0]  grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic b, input logic [1:0] g,
                         input logic we, input logic [7:0] d, input logic [3:0] rdy);
    chk({tag, ".busy"},  32'(busy),          32'(b));
    chk({tag, ".grant"}, 32'(grant_id),      32'(g));
    chk({tag, ".wen"},   32'(fifo_write_en), 32'(we));
    chk({tag, ".data"},  32'(fifo_data_in),  32'(d));
    chk({tag, ".ready"}, 32'(req_ready),     32'(rdy));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    tick(); tick();
    chk_out("rst", 0, 0, 0, 8'h00, 4'b0000);
    rst_n = 1'b1;
    tick();
    chk_out("idle", 0, 0, 0, 8'h00, 4'b0000);

    // Lone producer 0, six words: re-granted back-to-back after four.
    req_valid = 4'b0001;
    req_data  = 32'h443322A0;
    settle();
    chk_out("t1_req", 0, 0, 0, 8'h00, 4'b0000);
    tick();
    for (int w = 0; w < 6; w++) begin
      req_data[7:0] = 8'hA0 + 8'(w);
      settle();
      chk_out("t1_w", 1, 0, 1, 8'hA0 + 8'(w), 4'b0001);
      tick();
    end
    req_valid = 4'b0000;
    settle();
    chk_out("t1_drop", 1, 0, 0, 8'h00, 4'b0000);
    tick();
    chk("t1_idle.busy", 32'(busy), 32'd0);

    // All four contend: 0,1,2,3,0 with four writes each, no gaps.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_data  = 32'h44332211;
    req_valid = 4'b1111;
    settle();
    chk_out("t2_req", 0, 0, 0, 8'h00, 4'b0000);
    tick();
    for (int c = 0; c < 20; c++) begin
      logic [1:0] g;
      g = 2'((c / 4) % 4);
      settle();
      chk_out("t2", 1, g, 1, 8'h11 * (8'(g) + 8'd1), 4'(1 << g));
      tick();
    end
    req_valid = 4'b0000;
    settle();
    chk_out("t2_drop", 1, 1, 0, 8'h00, 4'b0000);
    tick();
    chk("t2_idle.busy", 32'(busy), 32'd0);

    // Producer 2 stalls three cycles on full after two beats; beat count frozen.
    req_valid = 4'b0110;
    tick();
    for (int w = 0; w < 2; w++) begin
      settle();
      chk_out("t3_w", 1, 2, 1, 8'h33, 4'b0100);
      tick();
    end
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      settle();
      chk_out("t3_stall", 1, 2, 0, 8'h00, 4'b0000);
      tick();
    end
    fifo_full = 1'b0;
    for (int w = 0; w < 2; w++) begin
      settle();
      chk_out("t3_w2", 1, 2, 1, 8'h33, 4'b0100);
      tick();
    end
    chk_out("t3_next", 1, 1, 1, 8'h22, 4'b0010);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t3_idle.busy", 32'(busy), 32'd0);

    // Producer 1 drops after one beat while 3 waits; rr pointer then wraps to 0.
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    settle();
    chk_out("t4_w", 1, 1, 1, 8'h22, 4'b0010);
    tick();
    req_valid = 4'b1000;
    settle();
    chk_out("t4_drop", 1, 1, 0, 8'h00, 4'b0000);
    tick();
    chk_out("t4_g3", 1, 3, 1, 8'h44, 4'b1000);
    req_valid = 4'b0110;
    settle();
    chk_out("t4_g3_drop", 1, 3, 0, 8'h00, 4'b0000);
    tick();
    chk_out("t4_rr", 1, 1, 1, 8'h22, 4'b0010);
    req_valid = 4'b0000;
    tick();
    chk("t4_idle.busy", 32'(busy), 32'd0);

    // Reset in the middle of producer 2's burst.
    req_valid = 4'b0100;
    tick();
    for (int w = 0; w < 2; w++) begin
      settle();
      chk_out("t5_w", 1, 2, 1, 8'h33, 4'b0100);
      tick();
    end
    rst_n = 1'b0;
    req_valid = 4'b0101;
    settle();
    chk_out("t5_rst", 1, 2, 0, 8'h00, 4'b0000);
    tick();
    rst_n = 1'b1;
    settle();
    chk_out("t5_after", 0, 0, 0, 8'h00, 4'b0000);
    tick();
    chk_out("t5_g0", 1, 0, 1, 8'h11, 4'b0001);

    // Owner drops valid while full: burst ends without a write, grant moves on.
    req_valid = 4'b0100;
    fifo_full = 1'b1;
    settle();
    chk_out("t5_endfull", 1, 0, 0, 8'h00, 4'b0000);
    tick();
    chk_out("t5_g2", 1, 2, 0, 8'h00, 4'b0000);
    fifo_full = 1'b0;
    settle();
    chk_out("t5_g2w", 1, 2, 1, 8'h33, 4'b0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the team's 8-bit × 16-deep FIFO among `NUM_REQ` producers in the write clock domain. Each producer streams words over a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst, drives the FIFO's `write_en`/`data_in`, and backpressures on `fifo_full`. It sits directly in front of the FIFO's write side and is clocked by that side's clock.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of producers, 2..8.
- `DATA_W`, 8 — word width, equal to the FIFO word width.
- `MAX_BURST`, 4 — maximum words per grant, 1..16.

Ports:
- `clk`  in  1  — write-domain clock. One clock; all logic on its rising edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `req_valid`  in  NUM_REQ  — producer i has a word on its slice of `req_data`.
- `req_data`  in  NUM_REQ*DATA_W  — producer i's word is bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  — word of producer i is accepted this cycle.
- `fifo_full`  in  1  — FIFO full flag; a write is forbidden while it is high.
- `fifo_write_en`  out  1  — write strobe to the FIFO.
- `fifo_data_in`  out  DATA_W  — word to the FIFO.
- `grant_id`  out  clog2(NUM_REQ)  — index of the current owner; valid while `busy`=1.
- `busy`  out  1  — a grant is active.

## Operation
- State machine with two states, IDLE and GRANT. Registers: `grant_id`, `busy`, burst counter `beat_cnt` (clog2(MAX_BURST)+1 bits), and round-robin pointer `rr_ptr`.
- Arbitration: scan `req_valid` starting at `rr_ptr`, wrapping modulo NUM_REQ. The first set bit wins. On a grant to index i, `rr_ptr` becomes (i+1) mod NUM_REQ.
- IDLE → GRANT: when any `req_valid` is high. Load `grant_id`, set `busy`=1, clear `beat_cnt`.
- In GRANT, with g = `grant_id`:
  - `req_ready[g]` = `req_valid[g]` & !`fifo_full`. All other ready bits are 0.
  - `fifo_write_en` = `req_ready[g]`.
  - `fifo_data_in` = slice g of `req_data`. It is 0 when not writing.
  - Each write increments `beat_cnt`.
- Burst end, evaluated at the clock edge while in GRANT:
  - (a) a write occurs with `beat_cnt` = MAX_BURST-1, or
  - (b) `req_valid[g]` is 0.
  - `fifo_full`=1 with `req_valid[g]`=1 is a stall, not a burst end. The grant is held indefinitely and `beat_cnt` is frozen.
- On burst end, re-arbitrate in the same cycle over the current `req_valid`, excluding nothing.
  - If any request is present, go GRANT → GRANT with the new owner, with no bubble.
  - Otherwise go to IDLE.
  - A lone requester is re-granted back-to-back.
- Producer rule: `req_data[i]` is held stable while `req_valid[i]`=1 and `req_ready[i]`=0. The arbiter never drops or duplicates an accepted word.
- The FIFO's `fifo_full` is registered and may lag by one cycle. The arbiter honours the flag as presented and adds no look-ahead.

## Timing
- Reset, at any clock edge with `rst_n`=0, including mid-burst:
  - State → IDLE, `busy`=0, `grant_id`=0, `beat_cnt`=0, `rr_ptr`=0.
  - `req_ready`, `fifo_write_en` and `fifo_data_in` are forced to 0 combinationally while `rst_n`=0.
  - A partially sent burst is abandoned. Words already written stay in the FIFO.
- Latency: `req_valid` rising in cycle N from IDLE gives the grant registered at edge N+1. The first write occurs in cycle N+1 if `fifo_full`=0.
- Throughput: one word per cycle inside a burst. Ownership changes at a burst end with zero idle cycles.
- Outputs are combinational from registered grant state plus `req_valid`/`fifo_full`. No combinational path from `req_data` to control outputs.
- Simultaneous events:
  - Burst-end condition (b) together with `fifo_full`=1: burst ends, no write.
  - Reset dominates all other conditions.

## Test plan
- Single producer, 0 sends 6 words, fifo_full=0, MAX_BURST=4 → write_en high for 4 cycles, one re-arbitration edge where producer 0 is re-granted, then 2 more writes; FIFO receives all 6 words in order.
- All 4 producers hold valid continuously, bursts of 4 → grant_id sequence 0,1,2,3,0; each owns exactly 4 consecutive writes; no idle cycles between bursts.
- fifo_full asserted for 3 cycles mid-burst of producer 2 after 2 beats → write_en and req_ready low for 3 cycles, grant_id stays 2, remaining 2 beats complete after full drops.
- Producer 1 drops valid after 1 beat while producer 3 is waiting → burst ends, grant moves to 3 on the next edge, rr_ptr=0 afterwards.
- rst_n low for 1 cycle during burst of producer 2 at beat 2 → write_en 0 during reset, busy=0 and grant_id=0 after the edge, the next grant starts from rr_ptr=0 (producer 0 wins if valid).
- Random valid/full traffic, 10k cycles → scoreboard: per-producer order preserved, no write while fifo_full, no burst exceeds MAX_BURST, no requester is starved beyond (NUM_REQ-1)×MAX_BURST writes by others.
